// File: rtl/key_event_scheduler_pkg.sv
// Shared types and constants for the key event scheduler.
package key_evt_pkg;

  localparam int unsigned EvtTypeW = 2;

  // Per-key debounce/classification FSM states.
  typedef enum logic [1:0] {
    StUp     = 2'd0,
    StDnFilt = 2'd1,
    StDown   = 2'd2,
    StUpFilt = 2'd3
  } key_st_e;

  localparam logic [EvtTypeW-1:0] EVT_PRESS   = 2'd0;
  localparam logic [EvtTypeW-1:0] EVT_LONG    = 2'd1;
  localparam logic [EvtTypeW-1:0] EVT_RELEASE = 2'd2;

endpackage

// File: rtl/key_event_scheduler_if.sv
// Event hand-off port: valid/ready with key index and event type.
interface key_event_scheduler_if
  import key_evt_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 4
) ();

  localparam int unsigned KeyW = $clog2(NUM_KEYS);

  logic                evt_valid;
  logic                evt_ready;
  logic [KeyW-1:0]     evt_key;
  logic [EvtTypeW-1:0] evt_type;

  modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);

endinterface

// File: rtl/key_event_scheduler_key_fsm.sv
// One key: synchronizer, debounce filter and PRESS/LONG/RELEASE classification.
module key_fsm
  import key_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned LONG_TICKS     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic tick,
  output logic key_state,
  output logic raise_press,
  output logic raise_long,
  output logic raise_release
);

  localparam int unsigned CntW  = $clog2(LONG_TICKS);
  localparam int unsigned UcntW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;

  localparam logic [CntW-1:0]  DebLast  = CntW'(DEBOUNCE_TICKS - 1);
  localparam logic [CntW-1:0]  LongLast = CntW'(LONG_TICKS - 1);
  localparam logic [UcntW-1:0] UdebLast = UcntW'(DEBOUNCE_TICKS - 1);

  logic [1:0]       sync_q;
  logic             sync;
  key_st_e          state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [UcntW-1:0] ucnt_q, ucnt_d;
  logic             long_done_q, long_done_d;

  assign sync      = sync_q[1];
  assign key_state = (state_q == StDown) || (state_q == StUpFilt);

  // Two-flop synchronizer for the raw key level.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], key_raw};
  end

  // FSM and counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StUp;
      cnt_q       <= '0;
      ucnt_q      <= '0;
      long_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ucnt_q      <= ucnt_d;
      long_done_q <= long_done_d;
    end
  end

  // Next state; a level change beats a coincident tick.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ucnt_d        = ucnt_q;
    long_done_d   = long_done_q;
    raise_press   = 1'b0;
    raise_long    = 1'b0;
    raise_release = 1'b0;
    case (state_q)
      StUp: begin
        if (sync) begin
          state_d = StDnFilt;
          cnt_d   = '0;
        end
      end
      StDnFilt: begin
        if (!sync) begin
          state_d = StUp;
        end else if (tick) begin
          if (cnt_q == DebLast) begin
            state_d     = StDown;
            cnt_d       = '0;
            raise_press = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDown: begin
        if (!sync) begin
          state_d = StUpFilt;
          ucnt_d  = '0;
        end else if (tick) begin
          // Hold count at LongLast; long_done keeps LONG to one per press.
          if (cnt_q == LongLast) begin
            if (!long_done_q) begin
              raise_long  = 1'b1;
              long_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StUpFilt: begin
        if (sync) begin
          state_d = StDown;
        end else if (tick) begin
          if (ucnt_q == UdebLast) begin
            state_d       = StUp;
            cnt_d         = '0;
            long_done_d   = 1'b0;
            raise_release = 1'b1;
          end else begin
            ucnt_d = ucnt_q + 1'b1;
          end
        end
      end
      default: state_d = StUp;
    endcase
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Multi-key front end: shared tick, per-key FSMs, pending bits, RR arbiter, event register.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned LONG_TICKS     = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   key_in,
  key_event_scheduler_if.master evt,
  output logic [NUM_KEYS-1:0]   key_state,
  output logic                  overrun
);

  localparam int unsigned KeyW = $clog2(NUM_KEYS);
  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PreW-1:0]           pre_q;
  logic                      tick;
  // Pending bit order per key: [0] PRESS, [1] LONG, [2] RELEASE.
  logic [NUM_KEYS-1:0][2:0]  raise, clr, pend_q, pend_d;
  logic                      valid_q, valid_d;
  logic [KeyW-1:0]           key_q, key_d, rr_q, rr_d;
  logic [EvtTypeW-1:0]       type_q, type_d;
  logic                      overrun_q, overrun_d;

  assign tick = (pre_q == PreW'(TICK_DIV - 1));

  // Shared debounce time base.
  always_ff @(posedge clk) begin
    if (rst || tick) pre_q <= '0;
    else             pre_q <= pre_q + 1'b1;
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_fsm #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS)
    ) u_key_fsm (
      .clk           (clk),
      .rst           (rst),
      .key_raw       (key_in[k]),
      .tick          (tick),
      .key_state     (key_state[k]),
      .raise_press   (raise[k][0]),
      .raise_long    (raise[k][1]),
      .raise_release (raise[k][2])
    );
  end

  // Round-robin grant, type priority and pending update.
  always_comb begin
    int unsigned idx;
    logic        found;
    logic [KeyW-1:0] sel;
    idx     = 0;
    found   = 1'b0;
    sel     = '0;
    clr     = '0;
    valid_d = valid_q;
    key_d   = key_q;
    type_d  = type_q;
    rr_d    = rr_q;
    if (!valid_q || evt.evt_ready) begin
      valid_d = 1'b0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        idx = 32'(rr_q) + i;
        if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
        sel = KeyW'(idx);
        if (!found && (|pend_q[sel])) begin
          found   = 1'b1;
          valid_d = 1'b1;
          key_d   = sel;
          rr_d    = (idx == NUM_KEYS - 1) ? '0 : KeyW'(idx + 1);
          if (pend_q[sel][0]) begin
            type_d       = EVT_PRESS;
            clr[sel][0]  = 1'b1;
          end else if (pend_q[sel][1]) begin
            type_d       = EVT_LONG;
            clr[sel][1]  = 1'b1;
          end else begin
            type_d       = EVT_RELEASE;
            clr[sel][2]  = 1'b1;
          end
        end
      end
    end
    // A new raise beats a same-cycle grant and is not an overrun.
    pend_d    = (pend_q & ~clr) | raise;
    overrun_d = |(raise & pend_q & ~clr);
  end

  // Pending bits, pointer and registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      valid_q   <= 1'b0;
      key_q     <= '0;
      type_q    <= '0;
      rr_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      key_q     <= key_d;
      type_q    <= type_d;
      rr_q      <= rr_d;
      overrun_q <= overrun_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_key   = key_q;
  assign evt.evt_type  = type_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with small timing parameters.
module tb_key_event_scheduler;
  import key_evt_pkg::*;

  localparam int unsigned NK = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_state;
  logic          overrun;

  key_event_scheduler_if #(.NUM_KEYS(NK)) evt_if ();

  key_event_scheduler #(
    .NUM_KEYS       (NK),
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .LONG_TICKS     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .evt       (evt_if),
    .key_state (key_state),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ov_cnt = 0;
  int ks0_cnt = 0;
  int ev_key[$];
  int ev_type[$];
  int ev_cyc[$];

  // Event log of accepted handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        ev_key.push_back(int'(evt_if.evt_key));
        ev_type.push_back(int'(evt_if.evt_type));
        ev_cyc.push_back(cyc);
      end
      if (overrun) ov_cnt++;
      if (key_state[0]) ks0_cnt++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_key(input int i);
    return (i < ev_key.size()) ? ev_key[i] : -1;
  endfunction

  function automatic int get_type(input int i);
    return (i < ev_type.size()) ? ev_type[i] : -1;
  endfunction

  function automatic int get_cyc(input int i);
    return (i < ev_cyc.size()) ? ev_cyc[i] : -1000;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, int'(evt_if.evt_valid), 0);
    check({tag, "_key"}, int'(evt_if.evt_key), 0);
    check({tag, "_type"}, int'(evt_if.evt_type), 0);
    check({tag, "_kstate"}, int'(key_state), 0);
    check({tag, "_ovr"}, int'(overrun), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, ob, kb, n, hk, ht, instab;
    bit seen;
    evt_if.evt_ready = 1'b1;
    step(3);
    @(negedge clk);
    check_idle("rst_in");
    step(1);
    rst = 1'b0;
    step(2);
    @(negedge clk);
    check_idle("rst_out");

    // Single long-enough hold on key 2: one PRESS, no LONG; then RELEASE.
    step(1);
    b = ev_key.size();
    key_in[2] = 1'b1;
    n = 0;
    while (!key_state[2] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t1_kstate_lat_ok", int'(n >= 12 && n <= 15), 1);
    step(40 - n);
    check("t1_nev", ev_key.size() - b, 1);
    check("t1_key", get_key(b), 2);
    check("t1_type", get_type(b), int'(EVT_PRESS));
    key_in[2] = 1'b0;
    step(30);
    check("t1_nev_rel", ev_key.size() - b, 2);
    check("t1_rel_type", get_type(b + 1), int'(EVT_RELEASE));
    check("t1_rel_key", get_key(b + 1), 2);

    // Short pulses on key 0 are filtered out.
    b  = ev_key.size();
    kb = ks0_cnt;
    key_in[0] = 1'b1;
    step(1);
    key_in[0] = 1'b0;
    step(20);
    key_in[0] = 1'b1;
    step(5);
    key_in[0] = 1'b0;
    step(30);
    check("t2_nev", ev_key.size() - b, 0);
    check("t2_kstate", ks0_cnt - kb, 0);

    // Long hold on key 1 with a short release glitch.
    b = ev_key.size();
    key_in[1] = 1'b1;
    step(60);
    key_in[1] = 1'b0;
    step(3);
    key_in[1] = 1'b1;
    step(20);
    key_in[1] = 1'b0;
    step(40);
    check("t3_nev", ev_key.size() - b, 3);
    check("t3_t0", get_type(b), int'(EVT_PRESS));
    check("t3_t1", get_type(b + 1), int'(EVT_LONG));
    check("t3_t2", get_type(b + 2), int'(EVT_RELEASE));
    check("t3_k0", get_key(b), 1);
    check("t3_k1", get_key(b + 1), 1);
    check("t3_k2", get_key(b + 2), 1);

    // Simultaneous presses under back-pressure, then drain.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    evt_if.evt_ready = 1'b0;
    b = ev_key.size();
    key_in = 4'b1011;
    seen = 0; instab = 0; hk = -1; ht = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (evt_if.evt_valid) begin
        if (!seen) begin
          seen = 1;
          hk = int'(evt_if.evt_key);
          ht = int'(evt_if.evt_type);
        end else if (int'(evt_if.evt_key) != hk || int'(evt_if.evt_type) != ht) begin
          instab++;
        end
      end else if (seen) begin
        instab++;
      end
    end
    check("t4_valid_seen", int'(seen), 1);
    check("t4_stable", instab, 0);
    check("t4_held_key", hk, 0);
    check("t4_held_type", ht, int'(EVT_PRESS));
    check("t4_none_during_stall", ev_key.size() - b, 0);
    step(1);
    evt_if.evt_ready = 1'b1;
    step(10);
    check("t4_k0", get_key(b), 0);
    check("t4_k1", get_key(b + 1), 1);
    check("t4_k2", get_key(b + 2), 3);
    check("t4_ty1", get_type(b + 1), int'(EVT_PRESS));
    check("t4_ty2", get_type(b + 2), int'(EVT_PRESS));
    check("t4_b2b_1", get_cyc(b + 1) - get_cyc(b), 1);
    check("t4_b2b_2", get_cyc(b + 2) - get_cyc(b + 1), 1);
    key_in = '0;
    step(40);
    check("t4_nev_total", ev_key.size() - b, 9);
    check("t4_long_k0", get_key(b + 3), 0);
    check("t4_long_t0", get_type(b + 3), int'(EVT_LONG));

    // Overrun: key 3 pressed twice while its PRESS is still pending.
    b  = ev_key.size();
    ob = ov_cnt;
    evt_if.evt_ready = 1'b0;
    key_in[0] = 1'b1;
    step(25);
    key_in[0] = 1'b0;
    step(25);
    key_in[3] = 1'b1;
    step(25);
    key_in[3] = 1'b0;
    step(25);
    key_in[3] = 1'b1;
    step(25);
    check("t5_overrun", ov_cnt - ob, 1);
    check("t5_none_during_stall", ev_key.size() - b, 0);
    evt_if.evt_ready = 1'b1;
    step(10);
    check("t5_nev", ev_key.size() - b, 4);
    check("t5_e0", get_key(b) * 4 + get_type(b), 0 * 4 + int'(EVT_PRESS));
    check("t5_e1", get_key(b + 1) * 4 + get_type(b + 1), 3 * 4 + int'(EVT_PRESS));
    check("t5_e2", get_key(b + 2) * 4 + get_type(b + 2), 0 * 4 + int'(EVT_RELEASE));
    check("t5_e3", get_key(b + 3) * 4 + get_type(b + 3), 3 * 4 + int'(EVT_RELEASE));
    key_in[3] = 1'b0;
    step(30);

    // Reset mid-operation discards held event and restarts filtering.
    b = ev_key.size();
    evt_if.evt_ready = 1'b0;
    key_in[1] = 1'b1;
    step(25);
    check("t6_held_valid", int'(evt_if.evt_valid), 1);
    key_in[2] = 1'b1;
    step(6);
    check("t6_filtering", int'(key_state[2]), 0);
    rst = 1'b1;
    key_in[1] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    check_idle("t6_rst");
    n = 0;
    while (!key_state[2] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_debounce_len", n, 12);
    @(posedge clk);
    #1;
    check("t6_valid", int'(evt_if.evt_valid), 1);
    check("t6_key", int'(evt_if.evt_key), 2);
    check("t6_type", int'(evt_if.evt_type), int'(EVT_PRESS));
    step(5);
    check("t6_nev", ev_key.size() - b, 1);
    check("t6_ev_key", get_key(b), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
Multi-key front end that debounces NUM_KEYS raw key inputs using one shared time-base prescaler, classifies each key's activity into PRESS, LONG and RELEASE events, and hands them one at a time to the consumer over a valid/ready port. Keys are served by round-robin arbitration. The block sits between the board key pins and the control logic, replacing per-key free-running debounce counters.

Parameters:
NUM_KEYS, 4, number of key inputs (>=2)
TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz)
DEBOUNCE_TICKS, 20, ticks a new level must stay stable before it is accepted (>=2)
LONG_TICKS, 1000, ticks a key must stay down, counted from PRESS acceptance, before LONG is raised (>DEBOUNCE_TICKS)

Ports:
clk  in  1  single clock for the whole block
rst  in  1  synchronous, active-high reset
key_in  in  NUM_KEYS  raw asynchronous key levels, 1 = pressed
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event when evt_valid && evt_ready at a clk edge
evt_key  out  $clog2(NUM_KEYS)  index of the key that produced the event
evt_type  out  2  0 = PRESS, 1 = LONG, 2 = RELEASE, 3 unused
key_state  out  NUM_KEYS  debounced level per key (1 while in DOWN or UP_FILT)
overrun  out  1  one-cycle pulse: an event was raised while the same pending bit was already set

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all outputs 0; prescaler 0; every key FSM in UP with counter 0 and long_done 0; all pending bits 0; RR pointer 0; synchronizer flops 0.
- Each key_in bit passes through a 2-flop synchronizer (sync). All FSM decisions use sync.
- Prescaler counts 0..TICK_DIV-1 and wraps. tick is high for one cycle when count == TICK_DIV-1. tick is shared by all keys.
- Per-key FSM states are UP, DN_FILT, DOWN and UP_FILT. Each key has a counter cnt, wide enough for LONG_TICKS.
  - UP: sync=1 -> DN_FILT, cnt=0.
  - DN_FILT: sync=0 -> UP (glitch, no event). Otherwise cnt increments on tick. On the tick where cnt == DEBOUNCE_TICKS-1: go to DOWN, cnt=0, set pending PRESS.
  - DOWN: cnt increments on tick and saturates. On the tick where cnt == LONG_TICKS-1 and long_done=0: set pending LONG and set long_done=1. sync=0 -> UP_FILT; cnt is preserved.
  - UP_FILT: uses a separate filter count ucnt, cleared on entry. sync=1 -> DOWN (glitch; cnt resumes, no event). Otherwise ucnt increments on tick. On the tick where ucnt == DEBOUNCE_TICKS-1: go to UP, cnt=0, long_done=0, set pending RELEASE.
- Sync change and tick in the same cycle: the state transition wins and no count is taken.
- Pending bits: 3 per key (PRESS, LONG, RELEASE).
  - Set while already set: overrun pulses for 1 cycle and the bit stays set.
  - Set and clear (grant) of the same bit in the same cycle: the set wins and there is no overrun.
- Output register:
  - Loading: loads when evt_valid=0, or when evt_valid && evt_ready.
  - Key selection: round-robin over keys with any pending bit, searching from the RR pointer.
  - Type priority within a key: PRESS > LONG > RELEASE.
  - On load: the granted bit is cleared and the pointer moves to grant+1, wrapping at NUM_KEYS.
  - If nothing is pending, evt_valid drops after the handshake.
- evt_valid, evt_key and evt_type are registered and held stable until accepted.
- Back-to-back: one event per cycle while evt_ready=1.
- Latency: from a pending bit being set to evt_valid is 1 cycle when the output is free.
- Reset asserted mid-operation: all events are discarded, including any unaccepted held event.

Decomposition:
- Package key_evt_pkg holds:
  - the key FSM state enum (UP, DN_FILT, DOWN, UP_FILT);
  - the evt_type constants EVT_PRESS, EVT_LONG, EVT_RELEASE;
  - the evt_type width.
- Sub-module key_fsm, one instance per key, contains:
  - the synchronizer, FSM, counters and long_done;
  - inputs clk, rst, key_raw and tick;
  - outputs key_state and raise_press, raise_long, raise_release (1-cycle pulses).
- The top level contains the prescaler, pending bits, RR arbiter and output register.

Test Plan (TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=8, NUM_KEYS=4, evt_ready=1 unless noted):
- Hold key_in[2]=1 for 40 cycles -> exactly one PRESS event with evt_key=2; key_state[2]=1 about 2+3*4 cycles after the input edge; no LONG.
- 1-cycle and 5-cycle pulses on key_in[0] (both shorter than the debounce window) -> no events, key_state[0] stays 0.
- Hold key_in[1] for 60 cycles, then release -> events in order PRESS, LONG, RELEASE, all with evt_key=1; LONG appears once. A release glitch shorter than the window during DOWN produces no extra event and no second LONG.
- Press keys 0, 1 and 3 on the same cycle with evt_ready=0 for 50 cycles, then evt_ready=1 -> three PRESS events with keys 0, 1, 3 on consecutive cycles; evt_valid/evt_key stable throughout the stall.
- With evt_ready=0, complete press, release and press again on key 3 -> second PRESS set while pending gives a 1-cycle overrun pulse; after ready, PRESS then RELEASE delivered.
- Assert rst while evt_valid=1 and key 2 is in DN_FILT -> next cycle all outputs 0. With key_in[2] still high, a fresh PRESS arrives only after a full debounce window.
